// File: rtl/drac_pkg.sv
// Shared types for the icache refill path: line/beat widths and the
// state encoding of the L2 grant responder.
package drac_pkg;

    localparam int L2_ADDR_BLOCK_W = 26;
    localparam int L2_BEAT_W       = 128;
    localparam int L2_BEATS        = 4;
    localparam int L2_REQ_DEPTH    = 2;

    typedef logic [L2_ADDR_BLOCK_W-1:0]  addr_block_t;
    typedef logic [$clog2(L2_BEATS)-1:0] beat_idx_t;
    typedef logic [L2_BEAT_W-1:0]        l2_beat_t;

    typedef enum logic {
        L2_IDLE,
        L2_FETCH
    } l2_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with registered occupancy count.
// DEPTH must be a power of two >= 2; a push at full is accepted only with a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count != CNT_W'(DEPTH)) | do_pop);
    assign head    = storage[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Data storage needs no reset; the count decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/l2_grant_responder.sv
// Memory-side responder for icache acquire/grant refills: fetches each line
// beat by beat from a backing read port and streams the beats out as grants.
module l2_grant_responder
    import drac_pkg::*;
#(
    parameter int ADDR_BLOCK_W = L2_ADDR_BLOCK_W,
    parameter int BEAT_W       = L2_BEAT_W,
    parameter int BEATS        = L2_BEATS,
    parameter int BEAT_IDX_W   = $clog2(BEATS),
    parameter int REQ_DEPTH    = L2_REQ_DEPTH
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           acquire_valid_i,
    input  logic [ADDR_BLOCK_W-1:0]        acquire_addr_block_i,
    output logic                           acquire_ready_o,
    output logic                           grant_valid_o,
    output logic [BEAT_W-1:0]              grant_data_o,
    output logic [BEAT_IDX_W-1:0]          grant_addr_beat_o,
    input  logic                           grant_ready_i,
    output logic                           mem_req_valid_o,
    output logic [ADDR_BLOCK_W+BEAT_IDX_W-1:0] mem_req_addr_o,
    input  logic                           mem_req_ready_i,
    input  logic                           mem_resp_valid_i,
    input  logic [BEAT_W-1:0]              mem_resp_data_i,
    output logic                           busy_o
);

    localparam int CNT_W  = BEAT_IDX_W + 1;
    localparam int QCNT_W = $clog2(REQ_DEPTH) + 1;

    l2_state_e                 state;
    l2_state_e                 state_next;
    logic [ADDR_BLOCK_W-1:0]   cur_block;
    logic [ADDR_BLOCK_W-1:0]   q_head;
    logic [ADDR_BLOCK_W-1:0]   req_block;
    logic [QCNT_W-1:0]         q_count;
    logic                      q_empty;
    logic                      q_push;
    logic                      load;
    logic [BEAT_W-1:0]         buf_head;
    logic [CNT_W-1:0]          buf_count;
    logic [CNT_W-1:0]          req_cnt;
    logic [CNT_W-1:0]          resp_cnt;
    logic [CNT_W-1:0]          outstanding;
    logic [CNT_W:0]            in_flight;
    logic [BEAT_IDX_W-1:0]     grant_cnt;
    logic [BEAT_IDX_W-1:0]     req_idx;
    logic                      credit_ok;
    logic                      buf_push;
    logic                      buf_pop;
    logic                      last_grant;
    logic                      req_valid;
    logic                      req_fire;

    assign q_empty         = (q_count == '0);
    assign acquire_ready_o = (q_count != QCNT_W'(REQ_DEPTH));
    assign q_push          = acquire_valid_i & acquire_ready_o;

    sync_fifo #(.WIDTH(ADDR_BLOCK_W), .DEPTH(REQ_DEPTH)) u_acq_queue (
        .clk       (clk_i),
        .rst_n     (rstn_i),
        .push      (q_push),
        .push_data (acquire_addr_block_i),
        .pop       (load),
        .head      (q_head),
        .count     (q_count)
    );

    // Beats already buffered plus reads in flight never exceed the buffer
    // size, so a response always has a slot waiting for it.
    assign outstanding = req_cnt - resp_cnt;
    assign in_flight   = {1'b0, buf_count} + {1'b0, outstanding};
    assign credit_ok   = (in_flight < (CNT_W+1)'(BEATS));
    assign buf_push    = mem_resp_valid_i & (outstanding != '0);
    assign buf_pop     = grant_valid_o & grant_ready_i;
    assign last_grant  = buf_pop & (grant_cnt == BEAT_IDX_W'(BEATS - 1));

    sync_fifo #(.WIDTH(BEAT_W), .DEPTH(BEATS)) u_beat_buf (
        .clk       (clk_i),
        .rst_n     (rstn_i),
        .push      (buf_push),
        .push_data (mem_resp_data_i),
        .pop       (buf_pop),
        .head      (buf_head),
        .count     (buf_count)
    );

    assign grant_valid_o     = (buf_count != '0);
    assign grant_data_o      = grant_valid_o ? buf_head : '0;
    assign grant_addr_beat_o = grant_cnt;
    assign busy_o            = (state != L2_IDLE) | !q_empty;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= L2_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            L2_IDLE:  if (!q_empty)                state_next = L2_FETCH;
            L2_FETCH: if (last_grant && q_empty)   state_next = L2_IDLE;
            default:                               state_next = L2_IDLE;
        endcase
    end

    // In IDLE the first request goes out from the queue head in the pop cycle.
    always_comb begin
        load      = 1'b0;
        req_valid = 1'b0;
        req_block = cur_block;
        req_idx   = req_cnt[BEAT_IDX_W-1:0];
        case (state)
            L2_IDLE: begin
                load      = !q_empty;
                req_valid = !q_empty & credit_ok;
                req_block = q_head;
                req_idx   = '0;
            end
            L2_FETCH: begin
                load      = last_grant & !q_empty;
                req_valid = !req_cnt[BEAT_IDX_W] & credit_ok;
            end
            default: ;
        endcase
    end

    assign req_fire        = req_valid & mem_req_ready_i;
    assign mem_req_valid_o = req_valid;
    assign mem_req_addr_o  = req_valid ? {req_block, req_idx} : '0;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cur_block <= '0;
            req_cnt   <= '0;
            resp_cnt  <= '0;
            grant_cnt <= '0;
        end else if (load) begin
            cur_block <= q_head;
            req_cnt   <= req_fire ? CNT_W'(1) : '0;
            resp_cnt  <= '0;
            grant_cnt <= '0;
        end else begin
            if (req_fire) req_cnt   <= req_cnt + CNT_W'(1);
            if (buf_push) resp_cnt  <= resp_cnt + CNT_W'(1);
            if (buf_pop)  grant_cnt <= grant_cnt + BEAT_IDX_W'(1);
        end
    end

    resp_protocol: assert property (@(posedge clk_i) disable iff (!rstn_i)
        mem_resp_valid_i |-> (outstanding != '0));

endmodule

// File: tb/tb_l2_grant_responder.sv
// Self-checking bench for l2_grant_responder: directed refill scenarios plus a
// randomized phase, checked against a line-level model of requests and grants.
module tb_l2_grant_responder;
    import drac_pkg::*;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          acquire_valid_i;
    addr_block_t   acquire_addr_block_i;
    logic          acquire_ready_o;
    logic          grant_valid_o;
    l2_beat_t      grant_data_o;
    beat_idx_t     grant_addr_beat_o;
    logic          grant_ready_i;
    logic          mem_req_valid_o;
    logic [27:0]   mem_req_addr_o;
    logic          mem_req_ready_i;
    logic          mem_resp_valid_i;
    l2_beat_t      mem_resp_data_i;
    logic          busy_o;

    l2_grant_responder dut (
        .clk_i                (clk_i),
        .rstn_i               (rstn_i),
        .acquire_valid_i      (acquire_valid_i),
        .acquire_addr_block_i (acquire_addr_block_i),
        .acquire_ready_o      (acquire_ready_o),
        .grant_valid_o        (grant_valid_o),
        .grant_data_o         (grant_data_o),
        .grant_addr_beat_o    (grant_addr_beat_o),
        .grant_ready_i        (grant_ready_i),
        .mem_req_valid_o      (mem_req_valid_o),
        .mem_req_addr_o       (mem_req_addr_o),
        .mem_req_ready_i      (mem_req_ready_i),
        .mem_resp_valid_i     (mem_resp_valid_i),
        .mem_resp_data_i      (mem_resp_data_i),
        .busy_o               (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        l2_beat_t    data;
        beat_idx_t   idx;
        addr_block_t blk;
    } exp_beat_t;

    exp_beat_t    exp_grant[$];
    logic [27:0]  exp_req[$];
    logic [27:0]  pend[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           req_fired = 0;
    int           grant_done = 0;
    int           req_mode = 0;
    int           resp_rate = 100;
    bit           grant_rand = 1'b0;
    addr_block_t  watch_end = '1;
    addr_block_t  watch_start = '1;
    int           last_end_cyc = -100;
    int           first_req_cyc = -200;

    function automatic l2_beat_t mem_data(input logic [27:0] a);
        return {a, 4'h1, a ^ 28'h5A5A5A5, 4'h2, ~a, 4'h3, a + 28'h1234567, 4'h4};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Line-level reference: every accepted acquire owes BEATS requests and
    // BEATS grants in order; memory answers requests in order.
    always @(negedge clk_i) begin
        if (rstn_i) begin
            check("busy", busy_o, exp_grant.size() != 0);
            if (exp_grant.size() == 0) check("acq_ready_idle", acquire_ready_o, 1'b1);
            if (mem_resp_valid_i && pend.size() != 0) void'(pend.pop_front());
            if (mem_req_valid_o) begin
                if (exp_req.size() == 0) check("req_extra", mem_req_valid_o, 1'b0);
                else begin
                    check("req_addr", mem_req_addr_o, exp_req[0]);
                    if (mem_req_ready_i) begin
                        check("credit", (req_fired - grant_done) < L2_BEATS, 1'b1);
                        if (mem_req_addr_o == {watch_start, 2'd0}) first_req_cyc = cyc;
                        pend.push_back(exp_req[0]);
                        void'(exp_req.pop_front());
                        req_fired++;
                    end
                end
            end
            if (grant_valid_o) begin
                if (exp_grant.size() == 0) check("grant_extra", grant_valid_o, 1'b0);
                else begin
                    check("grant_data", grant_data_o, exp_grant[0].data);
                    check("grant_idx", grant_addr_beat_o, exp_grant[0].idx);
                    if (grant_ready_i) begin
                        if (exp_grant[0].idx == 2'd3 && exp_grant[0].blk == watch_end)
                            last_end_cyc = cyc;
                        void'(exp_grant.pop_front());
                        grant_done++;
                    end
                end
            end
            if (acquire_valid_i && acquire_ready_o) begin
                for (int i = 0; i < L2_BEATS; i++) begin
                    exp_beat_t e;
                    e.blk  = acquire_addr_block_i;
                    e.idx  = beat_idx_t'(i);
                    e.data = mem_data({acquire_addr_block_i, beat_idx_t'(i)});
                    exp_grant.push_back(e);
                    exp_req.push_back({acquire_addr_block_i, beat_idx_t'(i)});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
        case (req_mode)
            0:       mem_req_ready_i = 1'b1;
            1:       mem_req_ready_i = ~mem_req_ready_i;
            default: mem_req_ready_i = 1'($urandom_range(1));
        endcase
        mem_resp_valid_i = (pend.size() != 0) && ($urandom_range(99) < resp_rate);
        mem_resp_data_i  = mem_resp_valid_i ? mem_data(pend[0]) : '0;
        if (grant_rand) grant_ready_i = ($urandom_range(3) != 0);
    endtask

    task automatic applyStimulus(input addr_block_t blk);
        bit ok = 1'b0;
        acquire_valid_i      = 1'b1;
        acquire_addr_block_i = blk;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk_i);
            if (acquire_ready_o) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("acq_accept", ok, 1'b1);
        step();
        acquire_valid_i = 1'b0;
    endtask

    task automatic drain(input string tag, input int bound);
        bit done = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk_i);
            if (exp_grant.size() == 0 && !busy_o) begin
                done = 1'b1;
                break;
            end
            step();
        end
        check(tag, done, 1'b1);
        step();
    endtask

    task automatic checkOutput(input string tag);
        check({tag, "_acq_ready"}, acquire_ready_o, 1'b1);
        check({tag, "_grant_valid"}, grant_valid_o, 1'b0);
        check({tag, "_grant_data"}, grant_data_o, '0);
        check({tag, "_grant_beat"}, grant_addr_beat_o, '0);
        check({tag, "_req_valid"}, mem_req_valid_o, 1'b0);
        check({tag, "_req_addr"}, mem_req_addr_o, '0);
        check({tag, "_busy"}, busy_o, 1'b0);
    endtask

    initial begin
        bit seen;
        rstn_i               = 1'b0;
        acquire_valid_i      = 1'b0;
        acquire_addr_block_i = '0;
        grant_ready_i        = 1'b1;
        mem_req_ready_i      = 1'b1;
        mem_resp_valid_i     = 1'b0;
        mem_resp_data_i      = '0;
        #12;
        checkOutput("reset");
        step();
        rstn_i = 1'b1;
        step();

        $display("[TB] single acquire latency");
        acquire_valid_i      = 1'b1;
        acquire_addr_block_i = 26'h0000040;
        @(negedge clk_i);
        check("t1_acq_ready", acquire_ready_o, 1'b1);
        step();
        acquire_valid_i = 1'b0;
        @(negedge clk_i);
        check("t1_first_req_valid", mem_req_valid_o, 1'b1);
        check("t1_first_req_addr", mem_req_addr_o, 28'h0000100);
        step();
        @(negedge clk_i);
        check("t1_no_grant_early", grant_valid_o, 1'b0);
        for (int i = 0; i < L2_BEATS; i++) begin
            step();
            @(negedge clk_i);
            check("t1_beat_valid", grant_valid_o, 1'b1);
            check("t1_beat_idx", grant_addr_beat_o, beat_idx_t'(i));
            check("t1_beat_data", grant_data_o, mem_data({26'h0000040, beat_idx_t'(i)}));
        end
        step();
        @(negedge clk_i);
        check("t1_busy_low", busy_o, 1'b0);
        step();

        $display("[TB] grant backpressure");
        grant_ready_i = 1'b0;
        applyStimulus(26'h0000040);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_i);
            if (grant_valid_o) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("t2_beat0_seen", seen, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk_i);
            check("t2_hold_valid", grant_valid_o, 1'b1);
            check("t2_hold_idx", grant_addr_beat_o, 2'd0);
        end
        step();
        grant_ready_i = 1'b1;
        drain("t2_drain", 200);

        $display("[TB] back-to-back acquires");
        watch_end   = 26'h10;
        watch_start = 26'h11;
        applyStimulus(26'h10);
        applyStimulus(26'h11);
        applyStimulus(26'h12);
        drain("t3_drain", 300);
        check("t3_no_bubble", first_req_cyc, last_end_cyc + 1);
        watch_end   = '1;
        watch_start = '1;

        $display("[TB] toggling mem_req_ready");
        req_mode = 1;
        applyStimulus(26'h33);
        drain("t4_drain", 300);
        req_mode = 0;

        $display("[TB] reset mid-line");
        applyStimulus(26'h50);
        seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk_i);
            if (grant_valid_o && grant_addr_beat_o == 2'd1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("t5_beat1_seen", seen, 1'b1);
        step();
        #2;
        rstn_i = 1'b0;
        exp_grant.delete();
        exp_req.delete();
        pend.delete();
        req_fired  = 0;
        grant_done = 0;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;
        #1;
        checkOutput("t5_reset");
        step();
        step();
        rstn_i = 1'b1;
        step();
        applyStimulus(26'h20);
        drain("t5_drain", 200);

        $display("[TB] randomized traffic");
        grant_rand = 1'b1;
        req_mode   = 2;
        resp_rate  = 60;
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(2)) step();
            applyStimulus(addr_block_t'($urandom));
        end
        drain("rand_drain", 3000);
        grant_rand    = 1'b0;
        grant_ready_i = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/l2_grant_responder.md
Name: l2_grant_responder

Overview:
- Synthesizable memory-side responder for the instruction-cache refill interface (acquire/grant).
- Accepts block-address acquires from the core's icache and fetches each line as BEATS beats from a generic backing-memory read port.
- Returns the beats on the grant channel tagged with their beat index.
- Replaces the behavioural line memory in FPGA and system builds; sits between top_drac and the L2/DRAM adapter.

Parameters:
- ADDR_BLOCK_W, 26, width of the line (block) address on acquire.
- BEAT_W, 128, grant data width per beat.
- BEATS, 4, beats per line (power of two, >=2).
- BEAT_IDX_W, $clog2(BEATS) = 2, width of the beat index.
- REQ_DEPTH, 2, acquire queue depth (power of two).

Ports:
- clk_i  in  1  core clock
- rstn_i  in  1  asynchronous active-low reset
- acquire_valid_i  in  1  refill request valid
- acquire_addr_block_i  in  ADDR_BLOCK_W  line address
- acquire_ready_o  out  1  acquire queue not full
- grant_valid_o  out  1  beat valid
- grant_data_o  out  BEAT_W  beat data
- grant_addr_beat_o  out  BEAT_IDX_W  beat index
- grant_ready_i  in  1  consumer accepts beat
- mem_req_valid_o  out  1  backing read request
- mem_req_addr_o  out  ADDR_BLOCK_W+BEAT_IDX_W  {block, beat}
- mem_req_ready_i  in  1  backing port accepts request
- mem_resp_valid_i  in  1  read data valid; in order, no backpressure
- mem_resp_data_i  in  BEAT_W  read data
- busy_o  out  1  transaction active or queue non-empty

Behaviour:
- Reset (async, rstn_i=0): all outputs 0 except acquire_ready_o=1; queues empty; FSM to IDLE; counters 0. Takes effect immediately, mid-transaction included; in-flight mem responses after reset release are dropped (drop counter = outstanding count captured at reset is NOT kept; the backing port must also be reset).
- Acquire queue:
  - FIFO of REQ_DEPTH block addresses.
  - Push on acquire_valid_i & acquire_ready_o.
  - acquire_ready_o = !full, registered-full based.
  - Push while full is impossible by handshake.
  - Simultaneous push and pop at full is not permitted (ready is 0).
- FSM states:
  - IDLE: queue non-empty -> pop head into cur_block, clear req_cnt/resp_cnt/grant_cnt, go FETCH.
  - FETCH: mem_req_valid_o = (req_cnt<BEATS) & credit>0, with mem_req_addr_o = {cur_block, req_cnt}. Increment req_cnt on mem_req_ready_i.
  - FETCH -> IDLE when the beat with grant_cnt==BEATS-1 handshakes on grant. If the queue is non-empty in that same cycle, stay in FETCH and load the next block directly, with no bubble.
- Beat buffer:
  - BEATS-entry FIFO of data.
  - Credit = BEATS - (occupancy + outstanding reads); outstanding = req_cnt - resp_cnt.
  - Guarantees mem_resp is never lost; overflow is impossible by construction.
  - Assert mem_resp_valid_i only when outstanding>0; mem_resp_valid_i with outstanding==0 is a protocol error, ignored, and flagged by a simulation assertion.
- Grant:
  - grant_valid_o = buffer non-empty; grant_data_o = head; grant_addr_beat_o = grant_cnt.
  - Outputs hold stable while valid & !ready.
  - grant_cnt increments on handshake and wraps to 0 after BEATS-1.
- Latency:
  - Acquire accepted at cycle T; IDLE pop at T+1; first mem request at T+1.
  - With zero-wait memory (response 1 cycle after request), the first grant beat is valid at T+3 and beats then stream one per cycle.
- Simultaneous events: push into the beat buffer and grant pop in the same cycle are both allowed, at any occupancy including full.
- busy_o = (state!=IDLE) | queue non-empty.

Decomposition:
- drac_pkg gains:
  - typedef addr_block_t (ADDR_BLOCK_W)
  - typedef beat_idx_t
  - typedef l2_beat_t (BEAT_W)
  - constant L2_BEATS
- One generic sub-module, sync_fifo (parameters WIDTH, DEPTH), instantiated twice: acquire queue and beat buffer.
- The FSM and counters stay in the top.

Test Plan:
1. Single acquire 26'h0000040, mem 1-cycle latency returning 128'hA0..A3, grant_ready_i=1 -> mem addrs 28'h0000100..28'h0000103, grant beats 0..3 with A0..A3 on 4 consecutive cycles; busy_o falls the cycle after beat 3.
2. Same acquire with grant_ready_i low for 5 cycles after beat 0 is valid -> beat 0 data/index held stable, at most 3 further mem requests issued (credit stops at BEATS), no data lost, order 0..3 preserved.
3. Three acquires 0x10, 0x11, 0x12 back-to-back -> acquire_ready_o drops after 2 queued, third accepted later. Grants are 12 beats in order, and the 0x11 requests start the cycle after 0x10 beat 3 handshakes (no bubble).
4. mem_req_ready_i toggling 1-0-1-0 -> mem_req_valid_o with stable addr held during stalls; each beat requested exactly once.
5. rstn_i asserted after beat 1 of a line is granted -> all outputs 0 and acquire_ready_o=1 immediately. After release, a new acquire 0x20 completes with beat indices starting at 0.
